// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor FSM state encoding.
// The vending FSM imports the same coin code constants.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_ONE  = 2'd1;
    localparam logic [1:0] COIN_TWO  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EMIT    = 3'd1,
        ST_REJECT  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLD    = 3'd4
    } coin_state_t;

    // Increment an 8-bit statistic, holding at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// Conditioning for one raw coin sensor: 2-flop synchroniser followed
// by a debounce counter. The debounced level changes only after the
// synchronised value has differed from it for DEBOUNCE consecutive cycles.
module coin_debounce #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam logic [7:0] LP_LAST = 8'(DEBOUNCE - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;
    logic       r_level;

    // Synchronise the raw input, then count cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_cnt == LP_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces two coin sensors, emits a single
// one-cycle coin code per accepted coin, or a reject pulse for ambiguous
// or locked-out insertions, then enforces a hold-off before re-arming.
// Optional macro COIN_ACCEPTOR_STATS_EN adds saturating 8-bit counters
// cnt_a, cnt_b and cnt_rej.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLDOFF  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_a,
    input  logic       sense_b,
    input  logic       lock,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
`ifdef COIN_ACCEPTOR_STATS_EN
   ,output logic [7:0] cnt_a,
    output logic [7:0] cnt_b,
    output logic [7:0] cnt_rej
`endif
);

    localparam logic [7:0] LP_HOLD = 8'(HOLDOFF);

    logic        w_lvl_a;
    logic        w_lvl_b;
    coin_state_t r_state;
    coin_state_t w_next;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_next;
    logic [1:0]  w_code;
    logic [1:0]  r_coin;
    logic        r_reject;
    logic        r_busy;

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (sense_a),
        .level (w_lvl_a)
    );

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (sense_b),
        .level (w_lvl_b)
    );

    // State and hold-off counter registers; reset parks in RELEASE so a
    // sensor held through reset is never taken as a coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RELEASE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            r_hold  <= w_hold_next;
        end
    end

    // Next-state, hold-off and coin-code selection.
    always_comb begin
        w_next      = r_state;
        w_hold_next = r_hold;
        w_code      = COIN_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_lvl_a || w_lvl_b) begin
                    if (lock || (w_lvl_a && w_lvl_b)) begin
                        w_next = ST_REJECT;
                    end else if (w_lvl_a) begin
                        w_code = COIN_ONE;
                        w_next = ST_EMIT;
                    end else begin
                        w_code = COIN_TWO;
                        w_next = ST_EMIT;
                    end
                end
            end
            ST_EMIT:   w_next = ST_RELEASE;
            ST_REJECT: w_next = ST_RELEASE;
            ST_RELEASE: begin
                if (!w_lvl_a && !w_lvl_b) begin
                    w_hold_next = LP_HOLD;
                    w_next      = (LP_HOLD == 8'd0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_lvl_a || w_lvl_b) begin
                    w_next = ST_RELEASE;
                end else if (r_hold <= 8'd1) begin
                    w_hold_next = '0;
                    w_next      = ST_IDLE;
                end else begin
                    w_hold_next = r_hold - 8'd1;
                end
            end
            default: w_next = ST_RELEASE;
        endcase
    end

    // Registered outputs decoded from the next state so the coin/reject
    // pulse coincides with the EMIT/REJECT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            r_coin   <= (w_next == ST_EMIT) ? w_code : COIN_NONE;
            r_reject <= (w_next == ST_REJECT);
            r_busy   <= (w_next != ST_IDLE);
        end
    end

    assign coin   = r_coin;
    assign reject = r_reject;
    assign busy   = r_busy;

`ifdef COIN_ACCEPTOR_STATS_EN
    logic [7:0] r_cnt_a;
    logic [7:0] r_cnt_b;
    logic [7:0] r_cnt_rej;

    // Saturating accept/reject statistics, stepped in EMIT/REJECT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_cnt_rej <= '0;
        end else begin
            if (r_state == ST_EMIT && r_coin == COIN_ONE) r_cnt_a <= sat_inc8(r_cnt_a);
            if (r_state == ST_EMIT && r_coin == COIN_TWO) r_cnt_b <= sat_inc8(r_cnt_b);
            if (r_state == ST_REJECT) r_cnt_rej <= sat_inc8(r_cnt_rej);
        end
    end

    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;
    assign cnt_rej = r_cnt_rej;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor (DEBOUNCE=4, HOLDOFF=8).
// Inputs change 1 time unit after a rising edge; that edge is "N", so a
// clean insertion yields the coin/reject pulse 7 edges later.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sense_a = 1'b0;
    logic       sense_b = 1'b0;
    logic       lock = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_rej;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int first_coin;
    int coin_val;
    int n_coin;
    int first_rej;
    int n_rej;
    int n_both;
    int took;
    int extra;

    coin_acceptor #(.DEBOUNCE(4), .HOLDOFF(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .sense_a (sense_a),
        .sense_b (sense_b),
        .lock    (lock),
        .coin    (coin),
        .reject  (reject),
        .busy    (busy)
`ifdef COIN_ACCEPTOR_STATS_EN
       ,.cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_rej (cnt_rej)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, recording coin/reject events relative to the start.
    task automatic watch(input int n);
        first_coin = -1; coin_val = 0; n_coin = 0;
        first_rej  = -1; n_rej = 0; n_both = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (coin != 2'd0) begin
                n_coin++;
                if (first_coin < 0) begin
                    first_coin = i;
                    coin_val   = int'(coin);
                end
            end
            if (reject) begin
                n_rej++;
                if (first_rej < 0) first_rej = i;
            end
            if (coin != 2'd0 && reject) n_both++;
        end
    endtask

    task automatic wait_idle(input int limit);
        took = 0;
        while (busy && took < limit) begin
            step();
            took++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_coin", int'(coin), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_busy", int'(busy), 1);
        rst = 1'b0;
        wait_idle(40);

        // Clean one-unit coin
        sense_a = 1'b1;
        watch(12);
        check("a_first_coin", first_coin, 7);
        check("a_coin_val", coin_val, 1);
        check("a_coin_cycles", n_coin, 1);
        check("a_no_reject", n_rej, 0);
        check("a_busy_held", int'(busy), 1);
        sense_a = 1'b0;
        wait_idle(40);
        check("holdoff_len", took, 15);

        // Bouncing two-unit sensor, then bounce during release
        for (int i = 0; i < 4; i++) begin
            sense_b = (i % 2 == 0);
            step();
        end
        sense_b = 1'b1;
        watch(12);
        check("b_first_coin", first_coin, 7);
        check("b_coin_val", coin_val, 2);
        check("b_coin_cycles", n_coin, 1);
        check("b_no_reject", n_rej, 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            sense_b = (i % 2 == 1);
            watch(1);
            extra += n_coin + n_rej;
        end
        sense_b = 1'b0;
        wait_idle(40);
        check("b_bounce_no_pulse", extra, 0);

        // Both sensors on the same edge
        sense_a = 1'b1; sense_b = 1'b1;
        watch(12);
        check("ab_first_rej", first_rej, 7);
        check("ab_rej_cycles", n_rej, 1);
        check("ab_no_coin", n_coin, 0);
        sense_a = 1'b0; sense_b = 1'b0;
        wait_idle(40);

        // Locked out insertion, then accepted after unlock
        lock = 1'b1; sense_a = 1'b1;
        watch(12);
        check("lock_first_rej", first_rej, 7);
        check("lock_rej_cycles", n_rej, 1);
        check("lock_no_coin", n_coin, 0);
        lock = 1'b0; sense_a = 1'b0;
        wait_idle(40);
        sense_a = 1'b1;
        watch(12);
        check("unlock_first_coin", first_coin, 7);
        check("unlock_coin_val", coin_val, 1);
        sense_a = 1'b0;
        wait_idle(40);

        // lock raised during EMIT does not affect the current coin
        sense_a = 1'b1;
        watch(7);
        check("emit_lock_coin", int'(coin), 1);
        lock = 1'b1;
        watch(6);
        check("emit_lock_no_rej", n_rej + n_coin, 0);
        lock = 1'b0; sense_a = 1'b0;
        wait_idle(40);

        // Re-insertion during HOLD returns to RELEASE without a coin
        sense_a = 1'b1;
        watch(12);
        check("hold_pre_coin", n_coin, 1);
        sense_a = 1'b0;
        watch(7);
        sense_a = 1'b1;
        watch(30);
        check("hold_reins_none", n_coin + n_rej, 0);
        check("hold_reins_busy", int'(busy), 1);
        sense_a = 1'b0;
        wait_idle(40);

        // Sensor held through reset is not accepted
        sense_a = 1'b1;
        rst = 1'b1; step(); step();
        rst = 1'b0;
        watch(30);
        check("held_rst_none", n_coin + n_rej, 0);
        check("held_rst_busy", int'(busy), 1);
        sense_a = 1'b0;
        wait_idle(40);
        sense_a = 1'b1;
        watch(12);
        check("after_held_coin", first_coin, 7);
        sense_a = 1'b0;
        wait_idle(40);

        // Reset during EMIT truncates the pulse asynchronously
        sense_a = 1'b1;
        watch(7);
        check("pre_rst_coin", int'(coin), 1);
        rst = 1'b1;
        #1;
        check("emit_rst_coin", int'(coin), 0);
        check("emit_rst_busy", int'(busy), 1);
        check("emit_rst_reject", int'(reject), 0);
        #2;
        rst = 1'b0;
        watch(20);
        check("emit_rst_no_repeat", n_coin + n_rej, 0);
        sense_a = 1'b0;
        wait_idle(40);

`ifdef COIN_ACCEPTOR_STATS_EN
        rst = 1'b1; step();
        rst = 1'b0;
        wait_idle(40);
        for (int k = 0; k < 300; k++) begin
            sense_a = 1'b1;
            watch(9);
            sense_a = 1'b0;
            wait_idle(40);
        end
        lock = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sense_a = 1'b1;
            watch(9);
            sense_a = 1'b0;
            wait_idle(40);
        end
        lock = 1'b0;
        check("stats_cnt_a", int'(cnt_a), 255);
        check("stats_cnt_b", int'(cnt_b), 0);
        check("stats_cnt_rej", int'(cnt_rej), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
